// File: rtl/fetch_unit.sv
// Fetch front end: owns the PC, issues 1-cycle-latency imem reads, buffers {inst, pc} for decode.
// Request to inst_valid is 2 cycles; fetch stalls when buffered + in-flight words would exceed the FIFO.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   input  logic        inst_ready
);

   localparam int          AW       = $clog2(FIFO_DEPTH);
   localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};

   logic [31:0] fetch_pc;
   logic [31:0] req_pc;
   logic        run;
   logic        inflight;

   logic [31:0] buf_data [FIFO_DEPTH];
   logic [31:0] buf_pc   [FIFO_DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [AW:0] occ;
   logic [AW+1:0] committed;
   logic        empty;
   logic        full;
   logic        pop;
   logic        push;
   logic        unused_bits;

   assign unused_bits = ^redirect_pc[1:0];

   assign occ   = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   assign inst_valid = ~empty;
   assign inst_data  = empty ? 32'd0 : buf_data[rd_ptr[AW-1:0]];
   assign inst_pc    = empty ? 32'd0 : buf_pc[rd_ptr[AW-1:0]];
   assign pop        = inst_valid & inst_ready;

   // Count the word already in flight so its response always has a free slot.
   assign committed = {1'b0, occ} + {{(AW+1){1'b0}}, inflight} - {{(AW+1){1'b0}}, pop};
   assign imem_req  = run & ~redirect_valid & (committed < (AW+2)'(FIFO_DEPTH));
   assign imem_addr = fetch_pc;

   // A response landing in a redirect cycle belongs to the old stream and is dropped.
   assign push = inflight & ~redirect_valid & ~full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc <= START_PC;
         req_pc   <= 32'd0;
         run      <= 1'b0;
         inflight <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else begin
         run      <= 1'b1;
         inflight <= imem_req;
         if (imem_req)
            req_pc <= fetch_pc;

         if (redirect_valid)
            fetch_pc <= {redirect_pc[31:2], 2'b00};
         else if (imem_req)
            fetch_pc <= fetch_pc + 32'd4;

         if (redirect_valid) begin
            rd_ptr <= wr_ptr;
         end else begin
            if (push)
               wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)
               rd_ptr <= rd_ptr + (AW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         buf_data[wr_ptr[AW-1:0]] <= imem_rdata;
         buf_pc[wr_ptr[AW-1:0]]   <= req_pc;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus async-reset and PC-wrap sequences.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'hDEAD_BEEF;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        inst_ready = 1'b0;

   logic        rst2_n = 1'b1;
   logic        imem_req2;
   logic [31:0] imem_addr2;
   logic [31:0] imem_rdata2 = 32'hDEAD_BEEF;
   logic        inst_valid2;
   logic [31:0] inst_data2;
   logic [31:0] inst_pc2;
   logic        ready2 = 1'b1;
   logic        redir2 = 1'b0;
   logic [31:0] rpc2 = 32'd0;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
      .inst_ready(inst_ready)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut_wrap (
      .clk(clk), .rst_n(rst2_n),
      .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
      .redirect_valid(redir2), .redirect_pc(rpc2),
      .inst_valid(inst_valid2), .inst_data(inst_data2), .inst_pc(inst_pc2),
      .inst_ready(ready2)
   );

   // Synchronous instruction memory: word at byte address A holds A>>2.
   always @(posedge clk) begin
      imem_rdata  <= imem_req  ? (imem_addr  >> 2) : 32'hDEAD_BEEF;
      imem_rdata2 <= imem_req2 ? (imem_addr2 >> 2) : 32'hDEAD_BEEF;
   end

   typedef struct {
      logic        rst;
      logic        rdy;
      logic        redir;
      logic [31:0] rpc;
      logic        req;
      logic [31:0] addr;
      logic        vld;
      logic [31:0] pc;
      logic [31:0] dat;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic rst, input logic rdy, input logic redir, input logic [31:0] rpc,
                      input logic req, input logic [31:0] addr,
                      input logic vld, input logic [31:0] pc, input logic [31:0] dat);
      vec_t v;
      v.rst = rst; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
      v.req = req; v.addr = addr; v.vld = vld; v.pc = pc; v.dat = dat;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk_dut(input string tag, input logic req, input logic [31:0] addr,
                          input logic vld, input logic [31:0] pc, input logic [31:0] dat);
      chk({tag, ".req"},  {31'd0, imem_req},   {31'd0, req});
      chk({tag, ".addr"}, imem_addr,           addr);
      chk({tag, ".vld"},  {31'd0, inst_valid}, {31'd0, vld});
      chk({tag, ".pc"},   inst_pc,             pc);
      chk({tag, ".dat"},  inst_data,           dat);
   endtask

   task automatic chk_wrap(input string tag, input logic req, input logic [31:0] addr,
                           input logic vld, input logic [31:0] pc, input logic [31:0] dat);
      chk({tag, ".req"},  {31'd0, imem_req2},   {31'd0, req});
      chk({tag, ".addr"}, imem_addr2,           addr);
      chk({tag, ".vld"},  {31'd0, inst_valid2}, {31'd0, vld});
      chk({tag, ".pc"},   inst_pc2,             pc);
      chk({tag, ".dat"},  inst_data2,           dat);
   endtask

   initial begin
      logic [31:0] wa [5];
      logic        wv [5];
      logic [31:0] wp [5];
      logic [31:0] wd [5];

      // rst rdy redir rpc | req addr vld pc dat
      // streaming with ready=1
      add(1,1,0,32'h0,   0,32'h00,  0,32'h00,32'h0);
      add(0,1,0,32'h0,   0,32'h00,  0,32'h00,32'h0);
      add(0,1,0,32'h0,   1,32'h00,  0,32'h00,32'h0);
      add(0,1,0,32'h0,   1,32'h04,  0,32'h00,32'h0);
      add(0,1,0,32'h0,   1,32'h08,  1,32'h00,32'h0);
      add(0,1,0,32'h0,   1,32'h0C,  1,32'h04,32'h1);
      add(0,1,0,32'h0,   1,32'h10,  1,32'h08,32'h2);
      add(0,1,0,32'h0,   1,32'h14,  1,32'h0C,32'h3);
      // stalled decode: four requests then hold
      add(1,0,0,32'h0,   0,32'h00,  0,32'h00,32'h0);
      add(0,0,0,32'h0,   0,32'h00,  0,32'h00,32'h0);
      add(0,0,0,32'h0,   1,32'h00,  0,32'h00,32'h0);
      add(0,0,0,32'h0,   1,32'h04,  0,32'h00,32'h0);
      add(0,0,0,32'h0,   1,32'h08,  1,32'h00,32'h0);
      add(0,0,0,32'h0,   1,32'h0C,  1,32'h00,32'h0);
      add(0,0,0,32'h0,   0,32'h10,  1,32'h00,32'h0);
      add(0,0,0,32'h0,   0,32'h10,  1,32'h00,32'h0);
      add(0,0,0,32'h0,   0,32'h10,  1,32'h00,32'h0);
      // drain from full with refill, order preserved
      add(0,1,0,32'h0,   1,32'h10,  1,32'h00,32'h0);
      add(0,0,0,32'h0,   0,32'h14,  1,32'h04,32'h1);
      add(0,1,0,32'h0,   1,32'h14,  1,32'h04,32'h1);
      add(0,1,0,32'h0,   1,32'h18,  1,32'h08,32'h2);
      add(0,1,0,32'h0,   1,32'h1C,  1,32'h0C,32'h3);
      // redirect while streaming at 0x20
      add(0,1,1,32'h43,  0,32'h20,  1,32'h10,32'h4);
      add(0,1,0,32'h0,   1,32'h40,  0,32'h00,32'h0);
      add(0,1,0,32'h0,   1,32'h44,  0,32'h00,32'h0);
      add(0,1,0,32'h0,   1,32'h48,  1,32'h40,32'h10);
      add(0,1,0,32'h0,   1,32'h4C,  1,32'h44,32'h11);
      // fill, then redirect with full FIFO and a pop
      add(0,0,0,32'h0,   1,32'h50,  1,32'h48,32'h12);
      add(0,0,0,32'h0,   1,32'h54,  1,32'h48,32'h12);
      add(0,0,0,32'h0,   0,32'h58,  1,32'h48,32'h12);
      add(0,0,0,32'h0,   0,32'h58,  1,32'h48,32'h12);
      add(0,1,1,32'h100, 0,32'h58,  1,32'h48,32'h12);
      add(0,1,0,32'h0,   1,32'h100, 0,32'h00,32'h0);
      add(0,1,0,32'h0,   1,32'h104, 0,32'h00,32'h0);
      add(0,1,0,32'h0,   1,32'h108, 1,32'h100,32'h40);
      // back-to-back redirects: last wins
      add(0,1,1,32'h203, 0,32'h10C, 1,32'h104,32'h41);
      add(0,1,1,32'h300, 0,32'h200, 0,32'h00,32'h0);
      add(0,1,0,32'h0,   1,32'h300, 0,32'h00,32'h0);
      add(0,1,0,32'h0,   1,32'h304, 0,32'h00,32'h0);
      add(0,1,0,32'h0,   1,32'h308, 1,32'h300,32'hC0);

      #2;
      rst_n  = 1'b0;
      rst2_n = 1'b0;

      foreach (vq[i]) begin
         @(negedge clk);
         rst_n          = ~vq[i].rst;
         inst_ready     = vq[i].rdy;
         redirect_valid = vq[i].redir;
         redirect_pc    = vq[i].rpc;
         #1;
         chk_dut($sformatf("v%0d", i), vq[i].req, vq[i].addr, vq[i].vld, vq[i].pc, vq[i].dat);
      end

      // async reset in the middle of a cycle, then restart at 0
      redirect_valid = 1'b0;
      inst_ready     = 1'b1;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_dut("arst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk_dut("arst.c0", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      @(negedge clk); #1;
      chk_dut("arst.c1", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
      @(negedge clk); #1;
      chk_dut("arst.c2", 1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
      @(negedge clk); #1;
      chk_dut("arst.c3", 1'b1, 32'h8, 1'b1, 32'h0, 32'h0);

      // PC wrap at the top of the address space
      wa[0] = 32'hFFFF_FFF8; wv[0] = 1'b0; wp[0] = 32'h0;         wd[0] = 32'h0;
      wa[1] = 32'hFFFF_FFFC; wv[1] = 1'b0; wp[1] = 32'h0;         wd[1] = 32'h0;
      wa[2] = 32'h0000_0000; wv[2] = 1'b1; wp[2] = 32'hFFFF_FFF8; wd[2] = 32'h3FFF_FFFE;
      wa[3] = 32'h0000_0004; wv[3] = 1'b1; wp[3] = 32'hFFFF_FFFC; wd[3] = 32'h3FFF_FFFF;
      wa[4] = 32'h0000_0008; wv[4] = 1'b1; wp[4] = 32'h0;         wd[4] = 32'h0;
      @(negedge clk);
      rst2_n = 1'b1;
      #1;
      chk_wrap("wrap.c0", 1'b0, 32'hFFFF_FFF8, 1'b0, 32'h0, 32'h0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk); #1;
         chk_wrap($sformatf("wrap.c%0d", c + 1), 1'b1, wa[c], wv[c], wp[c], wd[c]);
      end
      @(posedge clk);
      #3;
      rst2_n = 1'b0;
      #1;
      chk_wrap("wrap.arst", 1'b0, 32'hFFFF_FFF8, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      rst2_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         chk_wrap($sformatf("wrap.re%0d", c + 1), 1'b1, wa[c], wv[c], wp[c], wd[c]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
